// File: rtl/phrase_buffer.sv
// 32-character store feeding the LCD display unit: cursor-driven writes with
// backspace, cursor-home and a 32-cycle sequential clear.
module phrase_buffer #(
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter logic [7:0] BS_CHAR   = 8'h08,
  parameter bit         WRAP      = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] char_index,
  output logic [7:0] phrase,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  input  logic       cmd_clear,
  input  logic       cmd_home,
  output logic [4:0] cursor,
  output logic [5:0] count,
  output logic       full,
  output logic       busy,
  output logic       state_dbg
);

  // Write port handshake: a character transfers on a rising edge where
  // wr_valid & wr_ready; the producer holds wr_char stable while wr_ready is low.
  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t     state, state_nx;
  logic [4:0] clr_addr, clr_addr_nx, cursor_nx;
  logic [5:0] count_nx;
  logic       past_end, past_end_nx;
  logic [7:0] mem [32];
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;
  logic       accept;

  assign wr_ready  = (state == S_IDLE) && !cmd_clear && !cmd_home && !(!WRAP && past_end);
  assign accept    = wr_valid && wr_ready;
  assign phrase    = busy ? FILL_CHAR : mem[char_index];
  assign full      = (count == 6'd32);
  assign state_dbg = state;

  always_comb begin
    state_nx    = state;
    clr_addr_nx = clr_addr;
    cursor_nx   = cursor;
    count_nx    = count;
    past_end_nx = past_end;
    mem_we      = 1'b0;
    mem_addr    = cursor;
    mem_data    = wr_char;
    case (state)
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_addr;
        mem_data = FILL_CHAR;
        if (cmd_clear) begin
          clr_addr_nx = 5'd0;
        end else if (clr_addr == 5'd31) begin
          state_nx    = S_IDLE;
          clr_addr_nx = 5'd0;
          cursor_nx   = 5'd0;
          count_nx    = 6'd0;
          past_end_nx = 1'b0;
        end else begin
          clr_addr_nx = clr_addr + 5'd1;
        end
      end
      default: begin
        if (cmd_clear) begin
          state_nx    = S_CLEAR;
          clr_addr_nx = 5'd0;
        end else if (cmd_home) begin
          cursor_nx   = 5'd0;
          past_end_nx = 1'b0;
        end else if (accept) begin
          if (wr_char != BS_CHAR) begin
            mem_we   = 1'b1;
            mem_addr = cursor;
            mem_data = wr_char;
            // Without wrap the cursor parks on 31 and past_end marks the slot as used
            if (!WRAP && cursor == 5'd31) past_end_nx = 1'b1;
            else                          cursor_nx   = cursor + 5'd1;
            if (count != 6'd32) count_nx = count + 6'd1;
          end else if (past_end) begin
            mem_we      = 1'b1;
            mem_addr    = 5'd31;
            mem_data    = FILL_CHAR;
            past_end_nx = 1'b0;
            if (count != 6'd0) count_nx = count - 6'd1;
          end else if (cursor != 5'd0) begin
            mem_we    = 1'b1;
            mem_addr  = cursor - 5'd1;
            mem_data  = FILL_CHAR;
            cursor_nx = cursor - 5'd1;
            if (count != 6'd0) count_nx = count - 6'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_CLEAR;
      clr_addr <= 5'd0;
      cursor   <= 5'd0;
      count    <= 6'd0;
      past_end <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
      cursor   <= cursor_nx;
      count    <= count_nx;
      past_end <= past_end_nx;
      busy     <= (state_nx == S_CLEAR);
    end
  end

  // Contents are not reset; the clear sequence after reset release fills them.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_data;
  end

endmodule

// File: tb/tb_phrase_buffer.sv
// Bench for phrase_buffer: a WRAP=1 instance checked against a small model and
// scoreboard queue, plus a WRAP=0 instance sharing the same stimulus.
module tb_phrase_buffer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] char_index = 5'd0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_char = 8'h00;
  logic       cmd_clear = 1'b0;
  logic       cmd_home = 1'b0;

  logic [7:0] phrase, w0_phrase;
  logic       wr_ready, w0_wr_ready;
  logic [4:0] cursor, w0_cursor;
  logic [5:0] count, w0_count;
  logic       full, w0_full, busy, w0_busy, state_dbg, w0_state_dbg;

  phrase_buffer #(.WRAP(1'b1)) u_dut (
    .clock(clock), .reset(reset), .char_index(char_index), .phrase(phrase),
    .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(wr_ready),
    .cmd_clear(cmd_clear), .cmd_home(cmd_home), .cursor(cursor), .count(count),
    .full(full), .busy(busy), .state_dbg(state_dbg)
  );

  phrase_buffer #(.WRAP(1'b0)) u_dut_nowrap (
    .clock(clock), .reset(reset), .char_index(char_index), .phrase(w0_phrase),
    .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(w0_wr_ready),
    .cmd_clear(cmd_clear), .cmd_home(cmd_home), .cursor(w0_cursor), .count(w0_count),
    .full(w0_full), .busy(w0_busy), .state_dbg(w0_state_dbg)
  );

  // Clock / reset
  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_mem [32];
  logic [4:0] m_cursor;
  int         m_count;

  // Driver tasks
  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_cursor = 5'd0;
    m_count  = 0;
  endtask

  task automatic write_char(input logic [7:0] ch);
    wr_valid = 1'b1;
    wr_char  = ch;
    if (ch != 8'h08) begin
      m_mem[m_cursor] = ch;
      m_cursor = m_cursor + 5'd1;
      if (m_count < 32) m_count++;
    end else if (m_cursor != 5'd0) begin
      m_cursor = m_cursor - 5'd1;
      m_mem[m_cursor] = 8'h20;
      if (m_count > 0) m_count--;
    end
    @(negedge clock);
  endtask

  task automatic idle();
    wr_valid  = 1'b0;
    cmd_clear = 1'b0;
    cmd_home  = 1'b0;
  endtask

  // Scoreboard: expected bytes queued from the model, popped as each index is read
  task automatic scoreboard_drain(input string name);
    logic [7:0] exp;
    for (int i = 0; i < 32; i++) exp_q.push_back(m_mem[i]);
    for (int i = 0; i < 32; i++) begin
      char_index = 5'(i);
      #1;
      exp = exp_q.pop_front();
      n_checks++;
      if (phrase !== exp) begin
        n_fail++;
        $display("FAIL %s phrase[%0d]: got %h expected %h", name, i, phrase, exp);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (busy !== 1'b1 || cursor !== 5'd0 || count !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b cursor=%0d count=%0d expected 1/0/0", busy, cursor, count);
    end
    reset = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      char_index = 5'($urandom_range(0, 31));
      #1;
      n_checks++;
      if (phrase !== 8'h20) begin
        n_fail++;
        $display("FAIL reset_busy_phrase: idx %0d got %h expected 20", char_index, phrase);
      end
      n++;
      @(negedge clock);
    end
    n_checks++;
    if (n != 32) begin
      n_fail++;
      $display("FAIL reset_busy_cycles: got %0d expected 32", n);
    end
    n_checks++;
    if (cursor !== 5'd0 || count !== 6'd0 || wr_ready !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: cursor=%0d count=%0d ready=%b full=%b expected 0/0/1/0",
               cursor, count, wr_ready, full);
    end
    model_clear();
    scoreboard_drain("reset");
  endtask

  task automatic test_hello();
    logic [7:0] txt [5];
    txt = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    for (int i = 0; i < 5; i++) write_char(txt[i]);
    idle();
    n_checks++;
    if (cursor !== 5'd5 || count !== 6'd5) begin
      n_fail++;
      $display("FAIL hello_state: cursor=%0d count=%0d expected 5/5", cursor, count);
    end
    char_index = 5'd1;
    #1;
    n_checks++;
    if (phrase !== 8'h45) begin
      n_fail++;
      $display("FAIL hello_idx1: got %h expected 45", phrase);
    end
    char_index = 5'd5;
    #1;
    n_checks++;
    if (phrase !== 8'h20) begin
      n_fail++;
      $display("FAIL hello_idx5: got %h expected 20", phrase);
    end
    @(negedge clock);
    scoreboard_drain("hello");
  endtask

  task automatic test_backspace();
    write_char(8'h08);
    write_char(8'h08);
    idle();
    n_checks++;
    if (cursor !== 5'd3 || count !== 6'd3) begin
      n_fail++;
      $display("FAIL bs_state: cursor=%0d count=%0d expected 3/3", cursor, count);
    end
    scoreboard_drain("bs_two");
    repeat (5) write_char(8'h08);
    idle();
    n_checks++;
    if (cursor !== 5'd0 || count !== 6'd0) begin
      n_fail++;
      $display("FAIL bs_floor: cursor=%0d count=%0d expected 0/0", cursor, count);
    end
    scoreboard_drain("bs_floor");
  endtask

  task automatic test_home();
    for (int i = 0; i < 9; i++) write_char(8'h61 + 8'(i));
    idle();
    cmd_home = 1'b1;
    wr_valid = 1'b1;
    wr_char  = 8'h71;
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL home_ready: got %b expected 0", wr_ready);
    end
    @(negedge clock);
    idle();
    m_cursor = 5'd0;
    n_checks++;
    if (cursor !== 5'd0 || count !== 6'd9) begin
      n_fail++;
      $display("FAIL home_state: cursor=%0d count=%0d expected 0/9", cursor, count);
    end
    write_char(8'h51);
    idle();
    n_checks++;
    if (cursor !== 5'd1 || count !== 6'd10) begin
      n_fail++;
      $display("FAIL home_write: cursor=%0d count=%0d expected 1/10", cursor, count);
    end
    scoreboard_drain("home");
  endtask

  task automatic test_clear_collision();
    int n;
    cmd_clear = 1'b1;
    wr_valid  = 1'b1;
    wr_char   = 8'h5A;
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ready: got %b expected 0", wr_ready);
    end
    @(negedge clock);
    idle();
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    n_checks++;
    if (n != 32) begin
      n_fail++;
      $display("FAIL clear_busy_cycles: got %0d expected 32", n);
    end
    model_clear();
    n_checks++;
    if (cursor !== 5'd0 || count !== 6'd0 || w0_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_state: cursor=%0d count=%0d w0_busy=%b expected 0/0/0", cursor, count, w0_busy);
    end
    scoreboard_drain("clear");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 32; i++) write_char(8'h41 + 8'(i));
    wr_valid = 1'b1;
    wr_char  = 8'h61;
    #1;
    n_checks++;
    if (wr_ready !== 1'b1 || w0_wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_ready: wrap=%b nowrap=%b expected 1/0", wr_ready, w0_wr_ready);
    end
    m_mem[m_cursor] = 8'h61;
    m_cursor = m_cursor + 5'd1;
    @(negedge clock);
    idle();
    n_checks++;
    if (cursor !== 5'd1 || count !== 6'd32 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_state: cursor=%0d count=%0d full=%b expected 1/32/1", cursor, count, full);
    end
    n_checks++;
    if (w0_cursor !== 5'd31 || w0_count !== 6'd32 || w0_full !== 1'b1) begin
      n_fail++;
      $display("FAIL nowrap_state: cursor=%0d count=%0d full=%b expected 31/32/1", w0_cursor, w0_count, w0_full);
    end
    char_index = 5'd0;
    #1;
    n_checks++;
    if (phrase !== 8'h61 || w0_phrase !== 8'h41) begin
      n_fail++;
      $display("FAIL wrap_slot0: wrap=%h nowrap=%h expected 61/41", phrase, w0_phrase);
    end
    char_index = 5'd31;
    #1;
    n_checks++;
    if (w0_phrase !== 8'h60) begin
      n_fail++;
      $display("FAIL nowrap_slot31: got %h expected 60", w0_phrase);
    end
    @(negedge clock);
    scoreboard_drain("wrap");
  endtask

  task automatic test_reset_mid_clear();
    int n;
    cmd_clear = 1'b1;
    @(negedge clock);
    idle();
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || cursor !== 5'd0 || count !== 6'd0) begin
      n_fail++;
      $display("FAIL midclear_reset: busy=%b cursor=%0d count=%0d expected 1/0/0", busy, cursor, count);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    n_checks++;
    if (n != 32) begin
      n_fail++;
      $display("FAIL midclear_busy_cycles: got %0d expected 32", n);
    end
    model_clear();
    scoreboard_drain("midclear");
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_hello();
    test_backspace();
    test_home();
    test_clear_collision();
    test_wrap();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
